// File: rtl/mem_port_arb_pkg.sv
// Shared widths and owner-tag encodings for the memory port arbiter.
package mem_port_arb_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned BUS_WID = 32;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// 1-bit-wide synchronous FIFO holding the owner tag of each accepted memory request.
module arb_tag_fifo #(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            push_data,
    input  logic            pop,
    output logic            head,
    output logic [CntW-1:0] count,
    output logic            full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0] mem_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    assign full  = (count_q == CntW'(Depth));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A pop frees the slot a same-cycle push may reuse.
    assign pop_ok  = pop & (count_q != '0);
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// I/D memory port arbiter: D has fixed priority; MEM_ARB_STARVE_GUARD_EN adds an I starvation guard.
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned AW          = XLEN,
    parameter int unsigned DW          = BUS_WID,
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_resp,
    output logic [DW-1:0]   i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_resp,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_gnt,
    input  logic            m_resp,
    input  logic [DW-1:0]   m_rdata,
    input  logic            m_err
);

    localparam int unsigned CntW = $clog2(OUTSTANDING + 1);

    logic            force_i, sel_d, sel_i, hs;
    logic            fifo_full, fifo_empty, head, resp_ok, full_eff;
    logic [CntW-1:0] count;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt) starve_d = '0;
        else if (starve_q != 4'hf) starve_d = starve_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign force_i = i_req & (32'(starve_q) >= STARVE_MAX);
`else
    assign force_i = 1'b0;
`endif

    assign sel_d = d_req & ~force_i;
    assign sel_i = i_req & ~sel_d;

    // Responses with no outstanding tag are dropped rather than routed.
    assign fifo_empty = (count == '0);
    assign resp_ok    = m_resp & ~fifo_empty & ~rst;
    assign full_eff   = fifo_full & ~resp_ok;

    // Held off during reset so no handshake can lose its tag.
    assign m_req   = (sel_d | sel_i) & ~full_eff & ~rst;
    assign m_we    = sel_d & d_we;
    assign m_be    = sel_d ? d_be : (sel_i ? '1 : '0);
    assign m_addr  = sel_d ? d_addr : (sel_i ? i_addr : '0);
    assign m_wdata = sel_d ? d_wdata : '0;

    assign hs    = m_req & m_gnt;
    assign i_gnt = hs & sel_i;
    assign d_gnt = hs & sel_d;

    arb_tag_fifo #(
        .Depth (OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hs),
        .push_data (sel_d),
        .pop       (resp_ok),
        .head      (head),
        .count     (count),
        .full      (fifo_full)
    );

    assign i_resp  = resp_ok & (head == OWNER_I);
    assign d_resp  = resp_ok & (head == OWNER_D);
    assign i_rdata = i_resp ? m_rdata : '0;
    assign d_rdata = d_resp ? m_rdata : '0;
    assign i_err   = i_resp & m_err;
    assign d_err   = d_resp & m_err;

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (rst) !(m_resp && fifo_empty))
        else $warning("mem_port_arb: m_resp with no outstanding request dropped");
`endif

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed self-checking bench for mem_port_arb (OUTSTANDING = 2, STARVE_MAX = 4).
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_gnt, i_resp, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_resp, d_err;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_gnt, m_resp, m_err;
    logic [3:0]  m_be;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    mem_port_arb #(
        .AW          (32),
        .DW          (32),
        .OUTSTANDING (2),
        .STARVE_MAX  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_gnt   (i_gnt),
        .i_resp  (i_resp),
        .i_rdata (i_rdata),
        .i_err   (i_err),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_be    (d_be),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_resp  (d_resp),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_be    (m_be),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_gnt   (m_gnt),
        .m_resp  (m_resp),
        .m_rdata (m_rdata),
        .m_err   (m_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle, well away from the clock edge.
    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 0; m_resp = 0; m_rdata = '0; m_err = 0;
    endtask

    logic exp_d, exp_i;

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        settle();
        check("rst_m_req", 64'(m_req), 0);
        check("rst_i_gnt", 64'(i_gnt), 0);
        check("rst_d_resp", 64'(d_resp), 0);
        check("rst_count", 64'(dut.u_tag_fifo.count_q), 0);
        rst = 1'b0;
        tick();

        // I-only read
        i_req = 1; i_addr = 32'h100; m_gnt = 1;
        settle();
        check("i_rd_gnt", 64'(i_gnt), 1);
        check("i_rd_m_addr", 64'(m_addr), 64'h100);
        check("i_rd_m_we", 64'(m_we), 0);
        check("i_rd_m_be", 64'(m_be), 64'hf);
        tick();
        i_req = 0; m_gnt = 0;
        tick();
        m_resp = 1; m_rdata = 32'hDEADBEEF;
        settle();
        check("i_rd_resp", 64'(i_resp), 1);
        check("i_rd_rdata", 64'(i_rdata), 64'hDEADBEEF);
        check("i_rd_d_resp", 64'(d_resp), 0);
        tick();
        m_resp = 0; m_rdata = '0;
        settle();
        check("i_rd_count", 64'(dut.u_tag_fifo.count_q), 0);
        tick();

        // Conflict: D write wins, I follows
        i_req = 1; i_addr = 32'h104;
        d_req = 1; d_we = 1; d_be = 4'hf; d_addr = 32'h200; d_wdata = 32'h55;
        m_gnt = 1;
        settle();
        check("cf_d_gnt", 64'(d_gnt), 1);
        check("cf_i_gnt0", 64'(i_gnt), 0);
        check("cf_m_we", 64'(m_we), 1);
        check("cf_m_addr", 64'(m_addr), 64'h200);
        check("cf_m_wdata", 64'(m_wdata), 64'h55);
        tick();
        d_req = 0; d_we = 0;
        settle();
        check("cf_i_gnt1", 64'(i_gnt), 1);
        check("cf_m_addr_i", 64'(m_addr), 64'h104);
        tick();
        i_req = 0; m_gnt = 0;
        m_resp = 1; m_rdata = 32'h1;
        settle();
        check("cf_resp1_d", 64'(d_resp), 1);
        check("cf_resp1_i", 64'(i_resp), 0);
        tick();
        m_rdata = 32'h2;
        settle();
        check("cf_resp2_i", 64'(i_resp), 1);
        check("cf_resp2_d", 64'(d_resp), 0);
        check("cf_resp2_rdata", 64'(i_rdata), 64'h2);
        tick();
        m_resp = 0; m_rdata = '0;
        tick();

        // Full stall: two outstanding, third request waits for a response
        i_req = 1; i_addr = 32'h300; m_gnt = 1;
        settle();
        check("fs_gnt0", 64'(i_gnt), 1);
        tick();
        settle();
        check("fs_gnt1", 64'(i_gnt), 1);
        tick();
        settle();
        check("fs_m_req", 64'(m_req), 0);
        check("fs_gnt2", 64'(i_gnt), 0);
        check("fs_count", 64'(dut.u_tag_fifo.count_q), 2);
        tick();
        m_resp = 1; m_rdata = 32'hA5;
        settle();
        check("fs_gnt_on_resp", 64'(i_gnt), 1);
        check("fs_resp", 64'(i_resp), 1);
        tick();
        i_req = 0; m_gnt = 0;
        settle();
        check("fs_count_kept", 64'(dut.u_tag_fifo.count_q), 2);
        tick();
        tick();
        m_resp = 0; m_rdata = '0;
        settle();
        check("fs_drained", 64'(dut.u_tag_fifo.count_q), 0);
        tick();

        // Error routing on a D read
        d_req = 1; d_we = 0; d_be = 4'hf; d_addr = 32'h400; m_gnt = 1;
        settle();
        check("er_d_gnt", 64'(d_gnt), 1);
        tick();
        d_req = 0; m_gnt = 0;
        m_resp = 1; m_err = 1;
        settle();
        check("er_d_err", 64'(d_err), 1);
        check("er_i_err", 64'(i_err), 0);
        check("er_d_resp", 64'(d_resp), 1);
        tick();
        m_resp = 0; m_err = 0;
        tick();

        // Starvation: both request every cycle; a response each cycle keeps a slot free
        i_req = 1; i_addr = 32'h500;
        d_req = 1; d_we = 0; d_addr = 32'h600; m_gnt = 1;
        for (int c = 0; c < 6; c++) begin
            m_resp = (c != 0);
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_i = (c == 4);
`else
            exp_i = 1'b0;
`endif
            exp_d = ~exp_i;
            settle();
            check($sformatf("sv_d_gnt_c%0d", c), 64'(d_gnt), 64'(exp_d));
            check($sformatf("sv_i_gnt_c%0d", c), 64'(i_gnt), 64'(exp_i));
            tick();
        end
        i_req = 0; d_req = 0; m_gnt = 0;
        m_resp = 1;
        tick();
        m_resp = 0;
        settle();
        check("sv_drained", 64'(dut.u_tag_fifo.count_q), 0);
        tick();

        // Reset mid-flight: late response is dropped
        i_req = 1; i_addr = 32'h700; m_gnt = 1;
        settle();
        check("rm_gnt", 64'(i_gnt), 1);
        tick();
        i_req = 0; m_gnt = 0;
        rst = 1;
        tick();
        rst = 0;
        m_resp = 1; m_rdata = 32'h77;
        settle();
        check("rm_i_resp", 64'(i_resp), 0);
        check("rm_d_resp", 64'(d_resp), 0);
        tick();
        m_resp = 0;
        settle();
        check("rm_count", 64'(dut.u_tag_fifo.count_q), 0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Shares one memory port between two requesters: instruction fetch (I side) and load/store (D side).
- Sits between the fetch manager / LSU and the single external memory bus.
- Fixed priority: D over I, with a starvation guard that can be compiled in.
- Tracks outstanding accepted requests in an owner-tag FIFO and routes in-order responses back to the requester that issued them.

Parameters:
- AW, 32, address width.
- DW, 32, data width (equals BUS_WID).
- OUTSTANDING, 2, maximum accepted-but-unanswered requests; power of two, 1..8.
- STARVE_MAX, 4, consecutive cycles I may be denied while requesting before it is forced to win (guard only).

Ports:
- clk  in  1  clock, the single clock of the block.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  instruction read request.
- i_addr  in  AW  instruction address.
- i_gnt  out  1  I request accepted this cycle.
- i_resp  out  1  I response valid.
- i_rdata  out  DW  I read data.
- i_err  out  1  I bus error.
- d_req  in  1  data request.
- d_we  in  1  1 = write.
- d_be  in  DW/8  byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  D request accepted.
- d_resp  out  1  D response valid (reads and writes).
- d_rdata  out  DW  D read data.
- d_err  out  1  D bus error.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_be  out  DW/8  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_gnt  in  1  memory accepts m_req this cycle.
- m_resp  in  1  memory response, in order.
- m_rdata  in  DW  memory read data.
- m_err  in  1  memory error, qualified by m_resp.

Behaviour:
- Reset: all outputs 0; tag FIFO empty (count = 0, pointers = 0); starvation counter = 0.
- Select (combinational):
  - sel_d = d_req & ~force_i; sel_i = i_req & ~sel_d.
  - Without the guard, force_i = 0.
- Request mux:
  - m_req = (sel_d|sel_i) & ~full_eff, where full_eff = (count == OUTSTANDING) & ~m_resp. A response pops the FIFO in the same cycle, freeing a slot.
  - When sel_i: m_we = 0, m_be = all ones, m_wdata = 0.
  - When sel_d: m_addr, m_we, m_be, m_wdata are taken from the d_* inputs.
- Grants: i_gnt = m_req & m_gnt & sel_i; d_gnt = m_req & m_gnt & sel_d. These are zero-latency, same cycle as m_gnt.
- Requester rule: a requester holds its req and payload stable until its gnt. The arbiter does not latch requests.
- Tag FIFO:
  - On each handshake (m_req & m_gnt), push tag (1 = D, 0 = I).
  - On m_resp, pop the head.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo OUTSTANDING.
- Response routing (combinational, zero latency):
  - i_resp = m_resp & ~head; d_resp = m_resp & head.
  - rdata and err are forwarded to both sides, qualified by the corresponding resp.
- Boundaries:
  - m_resp with FIFO empty is a protocol violation. It is dropped: no resp asserted, count stays 0. A simulation-only assertion flags it.
  - FIFO full with no response: m_req = 0 and both gnts = 0.
  - Reset mid-transaction discards all tags; late m_resp is then dropped as above.
  - Back-to-back grants every cycle are allowed while slots remain.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A 3..4-bit counter increments each cycle i_req & ~i_gnt, and clears on i_gnt or ~i_req.
  - force_i = i_req & (cnt >= STARVE_MAX).
  - While force_i is set, D is masked for that arbitration.
- Undefined: force_i = 0, no counter exists, and D has strict priority.

Decomposition:
- Shared package/define file: AW/DW defaults tied to XLEN/BUS_WID, and the tag encodings OWNER_I = 0, OWNER_D = 1.
- One natural sub-module, arb_tag_fifo: a generic 1-bit-wide synchronous FIFO of depth OUTSTANDING with push, pop, head, count and full outputs, same clk/rst.

Test Plan:
- I-only read: i_req = 1, i_addr = 0x100, m_gnt = 1, then m_resp 2 cycles later with m_rdata = 0xDEADBEEF → i_gnt in cycle 0; i_resp = 1 and i_rdata = 0xDEADBEEF in cycle 2; d_resp stays 0.
- Conflict: i_req and d_req (write, addr 0x200, wdata 0x55) both high with m_gnt = 1 → d_gnt first, i_gnt next cycle. Responses in order produce d_resp, then i_resp.
- Full stall: OUTSTANDING = 2, two I grants and no m_resp, third i_req → m_req = 0 and i_gnt = 0. When m_resp arrives, i_gnt = 1 in that same cycle.
- Error routing: D read accepted, then m_resp = 1 and m_err = 1 → d_err = 1, i_err = 0.
- Starvation (macro defined, STARVE_MAX = 4): d_req and i_req held high with m_gnt = 1 → D granted in cycles 0-3, i_gnt = 1 in cycle 4, D resumes in cycle 5. Without the macro, I is never granted.
- Reset mid-flight: one outstanding I request, assert rst for 1 cycle, then m_resp → no i_resp or d_resp, count = 0.
